gate_round_scheduler: RTL
=========================

# gate_round_scheduler

Round sequencer for the logic-gate quiz game. Sits between the board keys/LFSR and the gate selector datapath: it tracks the player's gate selection, picks the next uncompleted target gate from the random source, judges confirm presses, and drives the timer enable and the VGA blank-out. It replaces ad-hoc key-edge logic with one synchronous FSM on `clk`.

## Interface
- `BLANK_CYCLES`, 25_000_000: clocks `vga_blankout` stays high after a miss (0.5 s at 50 MHz); minimum 1.
- `MAX_MISSES`, 3: miss limit; used only with `GATE_SCHED_MISS_LIMIT_EN`; minimum 1.

- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  synchronous, active-high reset.
- `switch_pulse`  in  1  one-cycle pulse: advance player selection (debounced KEY[2] edge).
- `confirm_pulse`  in  1  one-cycle pulse: confirm selection (debounced KEY[3] edge).
- `rand_in`  in  9  free-running random word; only `rand_in[3:0]` is used.
- `selected_gate`  out  8  player's current gate code.
- `current_gate`  out  8  target gate code fed to the gate selector.
- `completed`  out  9  bitmap; bit k set once gate index k has been answered correctly.
- `score`  out  4  correct answers, 0..9.
- `misses`  out  8  wrong answers, saturating at 255.
- `timer_en`  out  1  high while a game is in progress.
- `vga_blankout`  out  1  high during miss penalty.
- `playing`  out  1  high in PLAY.
- `done`  out  1  high in DONE.
- `game_over`  out  1  miss limit reached (constant 0 without the macro).

## Operation
- Gate index k (0..8) maps to code: k=0 -> 8'd0 (AND); k>=1 -> 8'd1 << (k-1) (OR, NAND, NOR, XOR, XNOR, SR, T, D).
- Player selection index `sel_idx`: on `switch_pulse` in IDLE, LOAD, PROBE or PLAY, sel_idx = (sel_idx==8) ? 0 : sel_idx+1. Ignored in BLANK and DONE.
- States:
  - IDLE: `confirm_pulse` -> LOAD.
  - LOAD: cand = rand_in[3:0] if <9, else rand_in[3:0]-9; -> PROBE.
  - PROBE: if completed[cand]==0, current_gate = code(cand), -> PLAY; else cand = (cand==8) ? 0 : cand+1, stay.
  - PLAY: `confirm_pulse` with sel_idx==cand: set completed[cand], score+1; if all 9 bits now set -> DONE, else -> LOAD. With sel_idx!=cand: misses+1 (saturating), load blank counter = BLANK_CYCLES-1, -> BLANK.
  - BLANK: counter decrements each clock; at 0 -> PLAY. Confirm ignored.
  - DONE: all pulses ignored; exit only by `reset`.
- Simultaneous `switch_pulse` and `confirm_pulse`: confirm acts, switch dropped; confirm compares pre-switch sel_idx.
- `confirm_pulse` in LOAD/PROBE ignored.

## Timing
- Reset values: selected_gate=0, current_gate=0, completed=0, score=0, misses=0, timer_en=0, vga_blankout=0, playing=0, done=0, game_over=0; state IDLE, sel_idx=0, cand=0.
- All outputs registered; reset mid-operation (any state, including BLANK mid-count) returns every output to its reset value next edge.
- `selected_gate` updates the clock after `switch_pulse`.
- `timer_en` rises the clock after the starting confirm; falls on the clock entering DONE.
- Pick latency: IDLE/PLAY confirm -> LOAD (1 clk) -> PROBE 1..9 clks -> PLAY. Worst case 11 clocks from confirm to `playing`.
- `vga_blankout` and BLANK are high for exactly BLANK_CYCLES clocks starting the clock after the wrong confirm; `playing` low for that span.
- Probe always terminates: entered only when at least one completed bit is clear.

## Configuration
- `GATE_SCHED_MISS_LIMIT_EN` defined: in PLAY a wrong confirm that brings misses to MAX_MISSES goes to DONE (not BLANK), sets `game_over`=1 and `done`=1, drops `timer_en`; `vga_blankout` stays 0.
- Not defined: misses unlimited (saturating), `game_over` tied 0, DONE reached only by completing all 9 gates.

## Test plan
- Reset, 10 `switch_pulse`s -> selected_gate sequence 1,2,4,8,16,32,64,128,0,1.
- `confirm_pulse` in IDLE with rand_in[3:0]=5 -> timer_en=1 next clock; current_gate=8'd16, playing=1 three clocks after confirm.
- BLANK_CYCLES=4, wrong confirm in PLAY -> misses=1, vga_blankout high exactly 4 clocks, confirm during blank ignored, then playing=1.
- completed[5]=1, rand_in[3:0]=14 (cand 5) -> probe skips to index 6, current_gate=8'd32.
- Answer all 9 correctly -> score=9, completed=9'h1FF, done=1, timer_en=0; later pulses change nothing.
- With macro, MAX_MISSES=2: two wrong confirms -> game_over=1, done=1, misses=2; without macro same stimulus -> misses=2, back to PLAY after blank.

Source files
------------

// File: rtl/gate_round_scheduler_if.sv
// Key/random inputs and round status outputs of the gate quiz round sequencer.
// master: key/LFSR side, slave: gate_round_scheduler.
interface gate_round_scheduler_if;
  logic       switch_pulse;
  logic       confirm_pulse;
  logic [8:0] rand_in;
  logic [7:0] selected_gate;
  logic [7:0] current_gate;
  logic [8:0] completed;
  logic [3:0] score;
  logic [7:0] misses;
  logic       timer_en;
  logic       vga_blankout;
  logic       playing;
  logic       done;
  logic       game_over;

  modport master (
    output switch_pulse, confirm_pulse, rand_in,
    input  selected_gate, current_gate, completed, score, misses,
           timer_en, vga_blankout, playing, done, game_over
  );

  modport slave (
    input  switch_pulse, confirm_pulse, rand_in,
    output selected_gate, current_gate, completed, score, misses,
           timer_en, vga_blankout, playing, done, game_over
  );
endinterface

// File: rtl/gate_round_scheduler.sv
// Round sequencer for the logic-gate quiz: selection, target pick, judging, miss penalty.
// Optional miss limit (MAX_MISSES ends the game) enabled by defining GATE_SCHED_MISS_LIMIT_EN.
module gate_round_scheduler #(
  parameter int unsigned BLANK_CYCLES = 25_000_000,
  parameter int unsigned MAX_MISSES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  gate_round_scheduler_if.slave bus
);

  localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PROBE, S_PLAY, S_BLANK, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       sel_idx_reg, sel_idx_next;
  logic [3:0]       cand_reg, cand_next;
  logic [7:0]       current_gate_reg, current_gate_next;
  logic [8:0]       completed_reg, completed_next;
  logic [3:0]       score_reg, score_next;
  logic [7:0]       misses_reg, misses_next;
  logic [CNT_W-1:0] blank_cnt_reg, blank_cnt_next;
  logic             game_over_reg, game_over_next;
  logic [7:0]       selected_gate_reg;
  logic             timer_en_reg, vga_blankout_reg, playing_reg, done_reg;

  logic       confirm_acts;
  logic [8:0] cand_mask;
  logic [3:0] rand_nib;
  logic [4:0] rand_hi_unused;

  assign rand_nib       = bus.rand_in[3:0];
  assign rand_hi_unused = bus.rand_in[8:4];
  assign cand_mask      = 9'd1 << cand_reg;

  // Index 0 (AND) is code 0; the rest are one-hot shifted down by one.
  function automatic logic [7:0] gate_code(input logic [3:0] k);
    return (k == 4'd0) ? 8'd0 : (8'd1 << (k - 4'd1));
  endfunction

  always_comb begin
    state_next        = state_reg;
    sel_idx_next      = sel_idx_reg;
    cand_next         = cand_reg;
    current_gate_next = current_gate_reg;
    completed_next    = completed_reg;
    score_next        = score_reg;
    misses_next       = misses_reg;
    blank_cnt_next    = blank_cnt_reg;
    game_over_next    = game_over_reg;

    confirm_acts = bus.confirm_pulse && (state_reg == S_IDLE || state_reg == S_PLAY);

    // A confirm that acts wins over a simultaneous switch and judges the old selection.
    if (bus.switch_pulse && !confirm_acts &&
        (state_reg == S_IDLE || state_reg == S_LOAD ||
         state_reg == S_PROBE || state_reg == S_PLAY))
      sel_idx_next = (sel_idx_reg == 4'd8) ? 4'd0 : sel_idx_reg + 4'd1;

    case (state_reg)
      S_IDLE: begin
        if (bus.confirm_pulse) state_next = S_LOAD;
      end
      S_LOAD: begin
        cand_next  = (rand_nib < 4'd9) ? rand_nib : rand_nib - 4'd9;
        state_next = S_PROBE;
      end
      S_PROBE: begin
        if ((completed_reg & cand_mask) == 9'd0) begin
          current_gate_next = gate_code(cand_reg);
          state_next        = S_PLAY;
        end else begin
          cand_next = (cand_reg == 4'd8) ? 4'd0 : cand_reg + 4'd1;
        end
      end
      S_PLAY: begin
        if (bus.confirm_pulse) begin
          if (sel_idx_reg == cand_reg) begin
            completed_next = completed_reg | cand_mask;
            score_next     = score_reg + 4'd1;
            state_next     = (completed_next == 9'h1FF) ? S_DONE : S_LOAD;
          end else begin
            misses_next = (misses_reg == 8'd255) ? 8'd255 : misses_reg + 8'd1;
`ifdef GATE_SCHED_MISS_LIMIT_EN
            if (32'(misses_next) == MAX_MISSES) begin
              game_over_next = 1'b1;
              state_next     = S_DONE;
            end else begin
              blank_cnt_next = CNT_W'(BLANK_CYCLES - 1);
              state_next     = S_BLANK;
            end
`else
            blank_cnt_next = CNT_W'(BLANK_CYCLES - 1);
            state_next     = S_BLANK;
`endif
          end
        end
      end
      S_BLANK: begin
        if (blank_cnt_reg == '0) state_next = S_PLAY;
        else                     blank_cnt_next = blank_cnt_reg - 1'b1;
      end
      S_DONE: ;
      default: state_next = S_IDLE;
    endcase
  end

`ifndef GATE_SCHED_MISS_LIMIT_EN
  logic [7:0] miss_limit_unused;
  assign miss_limit_unused = 8'(MAX_MISSES);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      sel_idx_reg       <= '0;
      cand_reg          <= '0;
      current_gate_reg  <= '0;
      completed_reg     <= '0;
      score_reg         <= '0;
      misses_reg        <= '0;
      blank_cnt_reg     <= '0;
      game_over_reg     <= 1'b0;
      selected_gate_reg <= '0;
      timer_en_reg      <= 1'b0;
      vga_blankout_reg  <= 1'b0;
      playing_reg       <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      sel_idx_reg       <= sel_idx_next;
      cand_reg          <= cand_next;
      current_gate_reg  <= current_gate_next;
      completed_reg     <= completed_next;
      score_reg         <= score_next;
      misses_reg        <= misses_next;
      blank_cnt_reg     <= blank_cnt_next;
      game_over_reg     <= game_over_next;
      // Status flags are decoded from the next state so they land with the state change.
      selected_gate_reg <= gate_code(sel_idx_next);
      timer_en_reg      <= (state_next == S_LOAD) || (state_next == S_PROBE) ||
                           (state_next == S_PLAY) || (state_next == S_BLANK);
      vga_blankout_reg  <= (state_next == S_BLANK);
      playing_reg       <= (state_next == S_PLAY);
      done_reg          <= (state_next == S_DONE);
    end
  end

  assign bus.selected_gate = selected_gate_reg;
  assign bus.current_gate  = current_gate_reg;
  assign bus.completed     = completed_reg;
  assign bus.score         = score_reg;
  assign bus.misses        = misses_reg;
  assign bus.timer_en      = timer_en_reg;
  assign bus.vga_blankout  = vga_blankout_reg;
  assign bus.playing       = playing_reg;
  assign bus.done          = done_reg;
  assign bus.game_over     = game_over_reg;

endmodule
